// File: rtl/acc_mem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : acc_mem_pkg
// Brief   : Shared types for the accelerator SRAM arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package acc_mem_pkg;

    typedef enum logic [1:0] {
        REQ_HOST  = 2'd0,
        REQ_FETCH = 2'd1,
        REQ_WB    = 2'd2
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t owner;
        logic    zero;
    } rsp_tag_t;

    // Round-robin successor: HOST -> FETCH -> WB -> HOST
    function automatic req_id_t next_req(input req_id_t id);
        case (id)
            REQ_HOST:  return REQ_FETCH;
            REQ_FETCH: return REQ_WB;
            default:   return REQ_HOST;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/acc_mem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : acc_mem_arbiter_if
// Brief   : Requester, response and SRAM signals of the accelerator arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface acc_mem_arbiter_if #(
    parameter int ADDR_SIZE = 16,
    parameter int DATA_W    = 8
);
    logic                 host_req_valid;
    logic                 host_req_ready;
    logic                 host_req_we;
    logic [ADDR_SIZE-1:0] host_req_addr;
    logic [DATA_W-1:0]    host_req_wdata;
    logic                 host_rsp_valid;
    logic [DATA_W-1:0]    host_rsp_data;

    logic                 fetch_req_valid;
    logic                 fetch_req_ready;
    logic [ADDR_SIZE-1:0] fetch_req_addr;
    logic                 fetch_lock;
    logic                 fetch_rsp_valid;
    logic [DATA_W-1:0]    fetch_rsp_data;

    logic                 wb_req_valid;
    logic                 wb_req_ready;
    logic [ADDR_SIZE-1:0] wb_req_addr;
    logic [DATA_W-1:0]    wb_req_wdata;

    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;

    // Arbiter side
    modport slave (
        input  host_req_valid, host_req_we, host_req_addr, host_req_wdata,
        output host_req_ready, host_rsp_valid, host_rsp_data,
        input  fetch_req_valid, fetch_req_addr, fetch_lock,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
        input  wb_req_valid, wb_req_addr, wb_req_wdata,
        output wb_req_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters and SRAM side
    modport master (
        output host_req_valid, host_req_we, host_req_addr, host_req_wdata,
        input  host_req_ready, host_rsp_valid, host_rsp_data,
        output fetch_req_valid, fetch_req_addr, fetch_lock,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
        output wb_req_valid, wb_req_addr, wb_req_wdata,
        input  wb_req_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/acc_mem_arbiter_rr.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter3
// Brief   : Three-way round-robin picker with exclusion mask, one-hot grant.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter3
    import acc_mem_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [2:0] i_excl,
    input  req_id_t    i_ptr,
    output logic [2:0] o_gnt
);

    logic [2:0] w_elig;

    assign w_elig = i_req & ~i_excl;

    // Bit index equals the req_id_t value; search starts at i_ptr
    always_comb begin
        o_gnt = 3'b000;
        case (i_ptr)
            REQ_FETCH: begin
                if (w_elig[1])      o_gnt = 3'b010;
                else if (w_elig[2]) o_gnt = 3'b100;
                else if (w_elig[0]) o_gnt = 3'b001;
            end
            REQ_WB: begin
                if (w_elig[2])      o_gnt = 3'b100;
                else if (w_elig[0]) o_gnt = 3'b001;
                else if (w_elig[1]) o_gnt = 3'b010;
            end
            default: begin
                if (w_elig[0])      o_gnt = 3'b001;
                else if (w_elig[1]) o_gnt = 3'b010;
                else if (w_elig[2]) o_gnt = 3'b100;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/acc_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module  : acc_mem_arbiter
// Brief   : Shares the single-port operand/result SRAM between host, operand
//           fetch and result writeback with fetch burst lock and zero point.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module acc_mem_arbiter
    import acc_mem_pkg::*;
#(
    parameter int                   ADDR_SIZE       = 16,
    parameter int                   DATA_W          = 8,
    parameter logic [ADDR_SIZE-1:0] ZERO_POINT_ADDR = 16'hffff,
    parameter int                   LOCK_MAX        = 64
)(
    input  logic              clk,
    input  logic              reset,
    acc_mem_arbiter_if.slave  bus
);

    localparam int                 c_cnt_w     = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_MAX - 1);

    req_id_t              r_rr_ptr;
    logic [c_cnt_w-1:0]   r_lock_cnt;
    logic                 r_last_fetch;
    rsp_tag_t             r_tag;
    logic [DATA_W-1:0]    r_host_hold;
    logic [DATA_W-1:0]    r_fetch_hold;
    logic [DATA_W-1:0]    r_wb_hold;

    logic [2:0]           w_req;
    logic [2:0]           w_excl;
    logic [2:0]           w_rr_gnt;
    logic [2:0]           w_gnt;
    logic                 w_lock;
    logic                 w_cnt_last;
    logic                 w_any;
    logic                 w_zero;
    req_id_t              w_gnt_id;
    logic                 w_we;
    logic [ADDR_SIZE-1:0] w_addr;
    logic [DATA_W-1:0]    w_wdata;
    logic [DATA_W-1:0]    w_rsp_data;
    logic                 w_host_rsp;
    logic                 w_fetch_rsp;
    logic                 w_wb_rsp;

    assign w_req      = {bus.wb_req_valid, bus.fetch_req_valid, bus.host_req_valid};
    assign w_cnt_last = (r_lock_cnt == c_lock_last);
    assign w_lock     = r_last_fetch & bus.fetch_lock & bus.fetch_req_valid
                      & (r_lock_cnt < c_lock_last);
    // An exhausted lock hands the slot to someone else only if someone is waiting
    assign w_excl     = {1'b0, w_cnt_last & (bus.host_req_valid | bus.wb_req_valid), 1'b0};

    rr_arbiter3 u_rr (
        .i_req  (w_req),
        .i_excl (w_excl),
        .i_ptr  (r_rr_ptr),
        .o_gnt  (w_rr_gnt)
    );

    always_comb begin
        w_gnt = 3'b000;
        if (!reset) begin
            w_gnt = w_lock ? 3'b010 : w_rr_gnt;
        end
    end

    assign w_any = |w_gnt;

    always_comb begin
        w_gnt_id = REQ_HOST;
        w_we     = 1'b0;
        w_addr   = '0;
        w_wdata  = '0;
        if (w_gnt[0]) begin
            w_gnt_id = REQ_HOST;
            w_we     = bus.host_req_we;
            w_addr   = bus.host_req_addr;
            w_wdata  = bus.host_req_wdata;
        end else if (w_gnt[1]) begin
            w_gnt_id = REQ_FETCH;
            w_addr   = bus.fetch_req_addr;
        end else if (w_gnt[2]) begin
            w_gnt_id = REQ_WB;
            w_we     = 1'b1;
            w_addr   = bus.wb_req_addr;
            w_wdata  = bus.wb_req_wdata;
        end
    end

    assign w_zero = w_any & ~w_we & (w_addr == ZERO_POINT_ADDR);

    assign bus.host_req_ready  = w_gnt[0];
    assign bus.fetch_req_ready = w_gnt[1];
    assign bus.wb_req_ready    = w_gnt[2];

    assign bus.mem_en    = w_any & ~w_zero;
    assign bus.mem_we    = w_any & w_we;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= REQ_HOST;
            r_lock_cnt   <= '0;
            r_last_fetch <= 1'b0;
            r_tag        <= '0;
        end else begin
            r_tag <= '{valid: w_any & ~w_we, owner: w_gnt_id, zero: w_zero};
            if (w_any) begin
                r_rr_ptr     <= next_req(w_gnt_id);
                r_last_fetch <= w_gnt[1];
            end
            if (!bus.fetch_lock) begin
                r_lock_cnt <= '0;
            end else if (w_lock) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end else if (w_any) begin
                r_lock_cnt <= '0;
            end
        end
    end

    // Read data is taken live from the SRAM in the response cycle, then held
    assign w_rsp_data  = r_tag.zero ? '0 : bus.mem_rdata;
    assign w_host_rsp  = ~reset & r_tag.valid & (r_tag.owner == REQ_HOST);
    assign w_fetch_rsp = ~reset & r_tag.valid & (r_tag.owner == REQ_FETCH);
    assign w_wb_rsp    = ~reset & r_tag.valid & (r_tag.owner == REQ_WB);

    assign bus.host_rsp_valid  = w_host_rsp;
    assign bus.fetch_rsp_valid = w_fetch_rsp;
    assign bus.host_rsp_data   = reset ? '0 : (w_host_rsp  ? w_rsp_data : r_host_hold);
    assign bus.fetch_rsp_data  = reset ? '0 : (w_fetch_rsp ? w_rsp_data : r_fetch_hold);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_host_hold  <= '0;
            r_fetch_hold <= '0;
            r_wb_hold    <= '0;
        end else begin
            if (w_host_rsp)  r_host_hold  <= w_rsp_data;
            if (w_fetch_rsp) r_fetch_hold <= w_rsp_data;
            if (w_wb_rsp)    r_wb_hold    <= w_rsp_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_acc_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_acc_mem_arbiter
// Brief   : Self-checking bench for acc_mem_arbiter against a reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_acc_mem_arbiter;
    import acc_mem_pkg::*;

    localparam int          c_lock_max = 4;
    localparam logic [15:0] c_zp       = 16'hffff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_ff = 1'b0;

    always #5 clk = ~clk;

    acc_mem_arbiter_if #(.ADDR_SIZE(16), .DATA_W(8)) bus ();

    acc_mem_arbiter #(
        .ADDR_SIZE       (16),
        .DATA_W          (8),
        .ZERO_POINT_ADDR (16'hffff),
        .LOCK_MAX        (c_lock_max)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // SRAM macro model: read data appears one cycle after the access
    logic [7:0] sram [0:65535];
    logic [7:0] sram_q;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            else            sram_q <= sram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = force_ff ? 8'hff : sram_q;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit [7:0] ref_mem [0:65535];
    int       m_ptr = 0;
    int       m_cnt = 0;
    bit       m_last_fetch = 1'b0;
    bit       p_valid = 1'b0;
    int       p_owner = 0;
    bit [7:0] p_data = 8'h00;
    bit [7:0] m_hold [3];
    int       gnt_log [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(bit hv, bit fv, bit wv, int ptr, int cnt);
        bit v [3];
        v[0] = hv;
        v[1] = fv && !((cnt == c_lock_max - 1) && (hv || wv));
        v[2] = wv;
        for (int k = 0; k < 3; k++) begin
            if (v[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic rsp_v(int r);
        case (r)
            0:       return bus.host_rsp_valid;
            1:       return bus.fetch_rsp_valid;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] rsp_d(int r);
        case (r)
            0:       return bus.host_rsp_data;
            1:       return bus.fetch_rsp_data;
            default: return 8'h00;
        endcase
    endfunction

    task automatic drive(input bit hv, input bit hwe, input logic [15:0] ha, input logic [7:0] hd,
                         input bit fv, input logic [15:0] fa, input bit fl,
                         input bit wv, input logic [15:0] wa, input logic [7:0] wd);
        bus.host_req_valid  = hv;
        bus.host_req_we     = hwe;
        bus.host_req_addr   = ha;
        bus.host_req_wdata  = hd;
        bus.fetch_req_valid = fv;
        bus.fetch_req_addr  = fa;
        bus.fetch_lock      = fl;
        bus.wb_req_valid    = wv;
        bus.wb_req_addr     = wa;
        bus.wb_req_wdata    = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    // One clock: check outputs against the model, then advance the model
    task automatic step();
        int          g;
        bit          locked;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wd;
        bit          zero;
        bit          ev;
        logic [7:0]  ed;
        #1;
        locked = !rst && m_last_fetch && bus.fetch_lock && bus.fetch_req_valid
                 && (m_cnt < c_lock_max - 1);
        if (rst)         g = -1;
        else if (locked) g = 1;
        else             g = pick(bus.host_req_valid, bus.fetch_req_valid, bus.wb_req_valid,
                                  m_ptr, m_cnt);
        we = 1'b0; addr = 16'h0; wd = 8'h0;
        case (g)
            0: begin we = bus.host_req_we; addr = bus.host_req_addr; wd = bus.host_req_wdata; end
            1: begin addr = bus.fetch_req_addr; end
            2: begin we = 1'b1; addr = bus.wb_req_addr; wd = bus.wb_req_wdata; end
            default: ;
        endcase
        zero = (g >= 0) && !we && (addr == c_zp);
        check_eq("ready", 32'({bus.wb_req_ready, bus.fetch_req_ready, bus.host_req_ready}),
                 (g < 0) ? 32'd0 : (32'd1 << g));
        check_eq("mem_en", 32'(bus.mem_en), 32'((g >= 0) && !zero));
        check_eq("mem_we", 32'(bus.mem_we), 32'((g >= 0) && we));
        if (g >= 0 && !zero) check_eq("mem_addr", 32'(bus.mem_addr), 32'(addr));
        if (g >= 0 && we)    check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
        for (int r = 0; r < 2; r++) begin
            ev = !rst && p_valid && (p_owner == r);
            ed = rst ? 8'h00 : (ev ? p_data : m_hold[r]);
            check_eq($sformatf("rsp_valid%0d", r), 32'(rsp_v(r)), 32'(ev));
            check_eq($sformatf("rsp_data%0d", r), 32'(rsp_d(r)), 32'(ed));
        end
        gnt_log.push_back(g);
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_cnt = 0; m_last_fetch = 1'b0; p_valid = 1'b0;
            for (int r = 0; r < 3; r++) m_hold[r] = 8'h00;
        end else begin
            if (p_valid) m_hold[p_owner] = p_data;
            p_valid = 1'b0;
            if (g >= 0) begin
                m_ptr = (g + 1) % 3;
                m_last_fetch = (g == 1);
                if (we) ref_mem[addr] = wd;
                else begin
                    p_valid = 1'b1;
                    p_owner = g;
                    p_data  = zero ? 8'h00 : ref_mem[addr];
                end
            end
            if (!bus.fetch_lock) m_cnt = 0;
            else if (locked)     m_cnt = m_cnt + 1;
            else if (g >= 0)     m_cnt = 0;
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] rnd_addr();
        return ($urandom_range(0, 7) == 0) ? c_zp : 16'($urandom_range(0, 15));
    endfunction

    int       share [3];
    int       order_bad;
    int       lock_pat [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit [7:0] b2b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        for (int r = 0; r < 3; r++) m_hold[r] = 8'h00;
        idle();
        rst = 1'b1;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Preload the working address range through the host port
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b1, 16'(a), 8'(a * 7 + 3), 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
            step();
        end

        // Host write then read back
        drive(1'b1, 1'b1, 16'h0010, 8'ha5, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        step();
        drive(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        step();
        idle();
        check_eq("host_rd_valid", 32'(bus.host_rsp_valid), 32'd1);
        check_eq("host_rd_data", 32'(bus.host_rsp_data), 32'ha5);
        check_eq("host_rd_no_fetch", 32'(bus.fetch_rsp_valid), 32'd0);
        step();

        // Fairness with all three requesters always valid
        gnt_log.delete();
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 8'($urandom),
                  1'b1, 16'($urandom_range(0, 15)), 1'b0,
                  1'b1, 16'($urandom_range(0, 15)), 8'($urandom));
            step();
        end
        share = '{0, 0, 0};
        order_bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (gnt_log[i] >= 0) share[gnt_log[i]]++;
            if (i > 0 && gnt_log[i] != (gnt_log[i-1] + 1) % 3) order_bad++;
        end
        check_eq("rr_share_host", 32'(share[0]), 32'd10);
        check_eq("rr_share_fetch", 32'(share[1]), 32'd10);
        check_eq("rr_share_wb", 32'(share[2]), 32'd10);
        check_eq("rr_order", 32'(order_bad), 32'd0);

        // Zero-point read with the SRAM output stuck at all ones
        idle();
        step();
        force_ff = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, c_zp, 1'b0, 1'b0, 16'h0, 8'h0);
        #1;
        check_eq("zp_mem_en", 32'(bus.mem_en), 32'd0);
        step();
        idle();
        check_eq("zp_rsp_valid", 32'(bus.fetch_rsp_valid), 32'd1);
        check_eq("zp_rsp_data", 32'(bus.fetch_rsp_data), 32'd0);
        step();
        force_ff = 1'b0;

        // Fetch lock against a waiting host, from a clean reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        gnt_log.delete();
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b0, 16'h0003, 8'h0, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0, 8'h0);
            step();
        end
        for (int i = 0; i < 11; i++) check_eq($sformatf("lock_seq%0d", i), 32'(gnt_log[i]),
                                              32'(lock_pat[i]));
        idle();
        step();

        // Back-to-back fetch reads return in address order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 16'(16'h0011 + i), b2b[i], 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'(16'h0011 + i), 1'b0, 1'b0, 16'h0, 8'h0);
            step();
            check_eq($sformatf("b2b_valid%0d", i), 32'(bus.fetch_rsp_valid), 32'd1);
            check_eq($sformatf("b2b_data%0d", i), 32'(bus.fetch_rsp_data), 32'(b2b[i]));
        end
        idle();
        step();

        // Reset lands in the response cycle of a host read
        drive(1'b1, 1'b0, 16'h0002, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        step();
        idle();
        rst = 1'b1;
        #1;
        check_eq("rst_drop_rsp", 32'(bus.host_rsp_valid), 32'd0);
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 16'h0004, 8'h0, 1'b1, 16'h0006, 1'b0, 1'b1, 16'h0007, 8'h5c);
        #1;
        check_eq("post_rst_host", 32'(bus.host_req_ready), 32'd1);
        check_eq("post_rst_no_rsp", 32'(bus.host_rsp_valid), 32'd0);
        step();

        // Randomized traffic with lock, zero point and occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), rnd_addr(), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom));
            step();
        end
        rst = 1'b0;
        idle();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/acc_mem_arbiter.md
Name: acc_mem_arbiter

Overview:
- Shares the accelerator's single-port operand/result SRAM between three requesters: the host bus, the accelerator operand fetch path, and the result writeback path.
- Does one memory access per cycle and returns read data one cycle after the grant.
- Reads of ZERO_POINT_ADDR are synthesized as zero and never reach the SRAM.
- Sits between the matrix controller/PE fetch logic and the SRAM macro.

Parameters:
- ADDR_SIZE, 16, memory address width.
- DATA_W, 8, memory word width.
- ZERO_POINT_ADDR, 16'hffff, read address that returns 0 without a memory access.
- LOCK_MAX, 64, maximum consecutive fetch grants under lock before a forced rotation.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- host_req_valid  in  1  host request present.
- host_req_ready  out  1  host request accepted this cycle.
- host_req_we  in  1  1 = write, 0 = read.
- host_req_addr  in  ADDR_SIZE  host address.
- host_req_wdata  in  DATA_W  host write data.
- host_rsp_valid  out  1  host read data valid.
- host_rsp_data  out  DATA_W  host read data.
- fetch_req_valid  in  1  operand fetch read request.
- fetch_req_ready  out  1  fetch request accepted.
- fetch_req_addr  in  ADDR_SIZE  fetch address.
- fetch_lock  in  1  burst lock; fetch keeps priority while high.
- fetch_rsp_valid  out  1  fetch read data valid.
- fetch_rsp_data  out  DATA_W  fetch read data.
- wb_req_valid  in  1  result write request.
- wb_req_ready  out  1  write accepted.
- wb_req_addr  in  ADDR_SIZE  write address.
- wb_req_wdata  in  DATA_W  write data.
- mem_en  out  1  SRAM access enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_SIZE  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_en with mem_we = 0.

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values:
  - rr_ptr = HOST; lock_cnt = 0.
  - All *_rsp_valid = 0; all *_rsp_data = 0.
  - mem_en = 0 and all *_req_ready = 0 during the reset cycle.
- Arbitration is combinational from the registered state and the current valids. At most one *_req_ready is high per cycle; a request is accepted when valid && ready.
- Round-robin order is HOST -> FETCH -> WB. Search starts at rr_ptr. After a grant, rr_ptr = successor of the granted requester.
- Lock rules:
  - Lock applies when the last grant was FETCH, fetch_lock = 1, fetch_req_valid = 1, and lock_cnt < LOCK_MAX-1. In that case FETCH is granted regardless of rr_ptr and lock_cnt increments.
  - lock_cnt clears on any non-FETCH grant or when fetch_lock = 0.
  - When lock_cnt reaches LOCK_MAX-1, the next cycle must grant another valid requester if one exists; FETCH is excluded from that cycle's search.
- Memory drive:
  - mem_en, mem_we, mem_addr and mem_wdata are combinational from the granted request, with zero latency.
  - mem_en = 0 when nothing is granted, and for a read of ZERO_POINT_ADDR.
  - A write to ZERO_POINT_ADDR is performed normally.
- Read response:
  - A registered tag {valid, owner, zero} is captured at grant.
  - In the next cycle, the owner's rsp_valid = 1 and rsp_data = (zero ? 0 : mem_rdata). rsp_data holds its value otherwise.
- Writes produce no response.
- Back-to-back reads: one response per cycle, in grant order.
- A requester with no valid is skipped; no idle grant is issued and rr_ptr does not move.
- Reset mid-operation: the in-flight read response is dropped (rsp_valid = 0 next cycle) and no memory access is issued in the reset cycle.

Decomposition:
- Package acc_mem_pkg:
  - typedef enum logic [1:0] {REQ_HOST, REQ_FETCH, REQ_WB} req_id_t.
  - Response tag struct {valid, req_id_t owner, zero}.
- One natural sub-module: rr_arbiter3, a pure 3-way round-robin with an exclusion mask input and grant one-hot output. Lock and the zero-point logic stay in the top module.

Test Plan:
- Host write 8'hA5 to 16'h0010, then host read 16'h0010: host_rsp_valid one cycle after the read grant, data 8'hA5; no fetch/wb responses.
- All three requesters valid continuously, no lock: grants cycle HOST, FETCH, WB, HOST...; each requester gets exactly 1/3 of grants over 30 cycles.
- Fetch read of 16'hffff: mem_en = 0 that cycle; next cycle fetch_rsp_valid = 1, fetch_rsp_data = 0, even with mem_rdata forced to 8'hFF.
- fetch_lock = 1 with host valid, LOCK_MAX = 4: exactly 4 consecutive FETCH grants, then one HOST grant, then FETCH resumes.
- Fetch reads to 16'h0011..16'h0014 back-to-back: four fetch_rsp_valid pulses on consecutive cycles, data in address order.
- Reset asserted the cycle after a host read grant: host_rsp_valid stays 0; after release, rr_ptr = HOST and the first grant goes to host if valid.
